// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle for axil_reg_bank: the five AXI4-Lite channels,
// with master/slave modports. Clock and reset are not part of the bundle.
interface axil_reg_bank_if #(
    parameter int ADDR_WIDTH = 40
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: NUM_CTRL RW control registers with byte strobes and
// write pulses, NUM_STAT RO status registers. Define AXIL_REG_BANK_SLVERR_EN to get SLVERR on bad indices.
module axil_reg_bank #(
    parameter int ADDR_WIDTH = 40,
    parameter int NUM_CTRL   = 8,
    parameter int NUM_STAT   = 4,
    parameter logic [NUM_CTRL*32-1:0] CTRL_RESET = '0,
    localparam int STAT_W = (NUM_STAT > 0) ? NUM_STAT * 32 : 32
) (
    input  logic                     axi_aclk,
    input  logic                     axi_aresetn,
    axil_reg_bank_if.slave           s_axi,
    output logic [NUM_CTRL*32-1:0]   ctrl_o,
    output logic [NUM_CTRL-1:0]      ctrl_wr_o,
    input  logic [STAT_W-1:0]        status_i
);

    localparam int NUM_REGS = NUM_CTRL + NUM_STAT;
    localparam int IDX_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

    logic                   awFull_q, awFull_d;
    logic [IDX_W-1:0]       awIdx_q, awIdx_d;
    logic                   wFull_q, wFull_d;
    logic [31:0]            wData_q, wData_d;
    logic [3:0]             wStrb_q, wStrb_d;
    logic                   bValid_q, bValid_d;
    logic [NUM_CTRL*32-1:0] ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]    ctrlWr_q, ctrlWr_d;
    logic                   rValid_q, rValid_d;
    logic [31:0]            rData_q, rData_d;

    logic             awReady, wReady, arReady;
    logic             awHs, wHs, arHs, execute;
    logic [IDX_W-1:0] execIdx, arIdx;
    logic [31:0]      execData, rdMux;
    logic [3:0]       execStrb;
    logic             unusedBits;

    assign awReady  = !awFull_q && !bValid_q;
    assign wReady   = !wFull_q && !bValid_q;
    assign arReady  = !rValid_q;
    assign awHs     = s_axi.awvalid && awReady;
    assign wHs      = s_axi.wvalid && wReady;
    assign arHs     = s_axi.arvalid && arReady;
    assign arIdx    = s_axi.araddr[IDX_W+1:2];

    // A handshake landing this cycle feeds the write directly, so AW+W together execute at once.
    assign execute  = (awFull_q || awHs) && (wFull_q || wHs);
    assign execIdx  = awFull_q ? awIdx_q : s_axi.awaddr[IDX_W+1:2];
    assign execData = wFull_q ? wData_q : s_axi.wdata;
    assign execStrb = wFull_q ? wStrb_q : s_axi.wstrb;

    assign unusedBits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

    always_comb begin
        awFull_d = awFull_q;
        awIdx_d  = awIdx_q;
        wFull_d  = wFull_q;
        wData_d  = wData_q;
        wStrb_d  = wStrb_q;
        bValid_d = bValid_q;
        ctrl_d   = ctrl_q;
        ctrlWr_d = '0;
        if (awHs) begin
            awFull_d = 1'b1;
            awIdx_d  = s_axi.awaddr[IDX_W+1:2];
        end
        if (wHs) begin
            wFull_d = 1'b1;
            wData_d = s_axi.wdata;
            wStrb_d = s_axi.wstrb;
        end
        if (execute) begin
            awFull_d = 1'b0;
            wFull_d  = 1'b0;
            bValid_d = 1'b1;
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (execIdx == IDX_W'(k)) begin
                    ctrlWr_d[k] = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (execStrb[b]) begin
                            ctrl_d[32*k+8*b +: 8] = execData[8*b +: 8];
                        end
                    end
                end
            end
        end else if (bValid_q && s_axi.bready) begin
            bValid_d = 1'b0;
        end
    end

    always_comb begin
        rdMux = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (arIdx == IDX_W'(k)) begin
                rdMux = ctrl_q[32*k +: 32];
            end
        end
        for (int k = 0; k < NUM_STAT; k++) begin
            if (arIdx == IDX_W'(NUM_CTRL + k)) begin
                rdMux = status_i[32*k +: 32];
            end
        end
        rValid_d = rValid_q;
        rData_d  = rData_q;
        if (arHs) begin
            rValid_d = 1'b1;
            rData_d  = rdMux;
        end else if (rValid_q && s_axi.rready) begin
            rValid_d = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            awFull_q <= 1'b0;
            awIdx_q  <= '0;
            wFull_q  <= 1'b0;
            wData_q  <= '0;
            wStrb_q  <= '0;
            bValid_q <= 1'b0;
            ctrl_q   <= CTRL_RESET;
            ctrlWr_q <= '0;
            rValid_q <= 1'b0;
            rData_q  <= '0;
        end else begin
            awFull_q <= awFull_d;
            awIdx_q  <= awIdx_d;
            wFull_q  <= wFull_d;
            wData_q  <= wData_d;
            wStrb_q  <= wStrb_d;
            bValid_q <= bValid_d;
            ctrl_q   <= ctrl_d;
            ctrlWr_q <= ctrlWr_d;
            rValid_q <= rValid_d;
            rData_q  <= rData_d;
        end
    end

`ifdef AXIL_REG_BANK_SLVERR_EN
    logic [1:0] bResp_q, bResp_d, rResp_q, rResp_d;

    // Only control indices accept writes; only mapped indices return data.
    always_comb begin
        bResp_d = bResp_q;
        rResp_d = rResp_q;
        if (execute) begin
            bResp_d = (int'(execIdx) < NUM_CTRL) ? 2'b00 : 2'b10;
        end
        if (arHs) begin
            rResp_d = (int'(arIdx) < NUM_REGS) ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            bResp_q <= 2'b00;
            rResp_q <= 2'b00;
        end else begin
            bResp_q <= bResp_d;
            rResp_q <= rResp_d;
        end
    end

    assign s_axi.bresp = bResp_q;
    assign s_axi.rresp = rResp_q;
`else
    assign s_axi.bresp = 2'b00;
    assign s_axi.rresp = 2'b00;
`endif

    assign s_axi.awready = awReady;
    assign s_axi.wready  = wReady;
    assign s_axi.bvalid  = bValid_q;
    assign s_axi.arready = arReady;
    assign s_axi.rvalid  = rValid_q;
    assign s_axi.rdata   = rData_q;
    assign ctrl_o        = ctrl_q;
    assign ctrl_wr_o     = ctrlWr_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank (8 control, 4 status registers).
// Expected values are hand-computed; responses follow AXIL_REG_BANK_SLVERR_EN when defined.
module tb_axil_reg_bank;

    localparam int NUM_CTRL = 8;
    localparam int NUM_STAT = 4;
    localparam logic [NUM_CTRL*32-1:0] CTRL_RESET =
        {192'd0, 32'h0000_1111, 32'hA5A5_0001};
`ifdef AXIL_REG_BANK_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic                   clock = 1'b0;
    logic                   resetN;
    logic [NUM_CTRL*32-1:0] ctrlO;
    logic [NUM_CTRL-1:0]    ctrlWrO;
    logic [NUM_STAT*32-1:0] statusI;
    logic [31:0]            expCtrl [NUM_CTRL];
    int                     checkCount = 0;
    int                     failCount  = 0;

    axil_reg_bank_if #(.ADDR_WIDTH(40)) bus ();

    axil_reg_bank #(
        .ADDR_WIDTH (40),
        .NUM_CTRL   (NUM_CTRL),
        .NUM_STAT   (NUM_STAT),
        .CTRL_RESET (CTRL_RESET)
    ) dut (
        .axi_aclk    (clock),
        .axi_aresetn (resetN),
        .s_axi       (bus.slave),
        .ctrl_o      (ctrlO),
        .ctrl_wr_o   (ctrlWrO),
        .status_i    (statusI)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [39:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic finishWrite();
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic checkAllCtrl(input string tag);
        for (int k = 0; k < NUM_CTRL; k++) begin
            checkOutput($sformatf("%s_ctrl%0d", tag, k), ctrlO[32*k +: 32], expCtrl[k]);
        end
    endtask

    initial begin
        resetN      = 1'b0;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        statusI     = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'hDEAD_BEEF};
        for (int k = 0; k < NUM_CTRL; k++) expCtrl[k] = 32'h0;
        expCtrl[0] = 32'hA5A5_0001;
        expCtrl[1] = 32'h0000_1111;

        tick();
        tick();
        resetN = 1'b1;
        tick();
        $display("[TB] reset state");
        checkAllCtrl("rst");
        checkOutput("rst_awready", 32'(bus.awready), 32'd1);
        checkOutput("rst_wready",  32'(bus.wready),  32'd1);
        checkOutput("rst_arready", 32'(bus.arready), 32'd1);
        checkOutput("rst_bvalid",  32'(bus.bvalid),  32'd0);
        checkOutput("rst_rvalid",  32'(bus.rvalid),  32'd0);
        checkOutput("rst_rdata",   bus.rdata,        32'd0);
        checkOutput("rst_ctrlwr",  32'(ctrlWrO),     32'd0);

        $display("[TB] simultaneous AW+W to reg2");
        applyStimulus(40'h08, 32'h1234_5678, 4'hF);
        expCtrl[2] = 32'h1234_5678;
        checkOutput("sim_reg2",    ctrlO[95:64],     expCtrl[2]);
        checkOutput("sim_ctrlwr",  32'(ctrlWrO),     32'h04);
        checkOutput("sim_bvalid",  32'(bus.bvalid),  32'd1);
        checkOutput("sim_bresp",   32'(bus.bresp),   32'd0);
        checkOutput("sim_awready", 32'(bus.awready), 32'd0);
        finishWrite();
        checkOutput("sim_bclr",    32'(bus.bvalid),  32'd0);
        checkOutput("sim_wrclr",   32'(ctrlWrO),     32'd0);

        $display("[TB] W leads AW by 3 cycles, byte strobe 0x2");
        applyStimulus(40'h00, 32'h0000_0000, 4'hF);
        finishWrite();
        checkOutput("clr_reg0", ctrlO[31:0], 32'h0);
        bus.wdata  = 32'hFFFF_FFFF;
        bus.wstrb  = 4'h2;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        checkOutput("wl_wready1", 32'(bus.wready),  32'd0);
        checkOutput("wl_bvalid0", 32'(bus.bvalid),  32'd0);
        tick();
        tick();
        checkOutput("wl_wready2", 32'(bus.wready),  32'd0);
        bus.awaddr  = 40'h00;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        expCtrl[0] = 32'h0000_FF00;
        checkOutput("wl_reg0",    ctrlO[31:0],      expCtrl[0]);
        checkOutput("wl_ctrlwr",  32'(ctrlWrO),     32'h01);
        checkOutput("wl_bvalid",  32'(bus.bvalid),  32'd1);
        tick();
        checkOutput("wl_wready3", 32'(bus.wready),  32'd0);
        checkOutput("wl_bhold",   32'(bus.bvalid),  32'd1);
        finishWrite();
        checkOutput("wl_wready4", 32'(bus.wready),  32'd1);

        $display("[TB] AW leads W, byte strobe 0x9");
        bus.awaddr  = 40'h0C;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        checkOutput("al_awready", 32'(bus.awready), 32'd0);
        checkOutput("al_wready",  32'(bus.wready),  32'd1);
        bus.wdata  = 32'h1122_3344;
        bus.wstrb  = 4'h9;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        expCtrl[3] = 32'h1100_0044;
        checkOutput("al_ctrlwr", 32'(ctrlWrO),    32'h08);
        checkOutput("al_bvalid", 32'(bus.bvalid), 32'd1);
        finishWrite();
        checkAllCtrl("al");

        $display("[TB] status read with rready held low");
        bus.araddr  = 40'(NUM_CTRL * 4);
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        statusI[31:0] = 32'h0BAD_F00D;
        checkOutput("st_rvalid",  32'(bus.rvalid),  32'd1);
        checkOutput("st_rdata",   bus.rdata,        32'hDEAD_BEEF);
        checkOutput("st_rresp",   32'(bus.rresp),   32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("st_hold_rdata%0d", c), bus.rdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("st_hold_arrdy%0d", c), 32'(bus.arready), 32'd0);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        checkOutput("st_rclr",    32'(bus.rvalid),  32'd0);
        checkOutput("st_arready", 32'(bus.arready), 32'd1);

        $display("[TB] last status index, ignored address bits");
        bus.araddr  = 40'h2C;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        tick();
        checkOutput("st3_rdata", bus.rdata, 32'h4444_0003);
        bus.arvalid = 1'b0;
        tick();
        bus.araddr  = 40'h01_0000_000A;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        checkOutput("alias_rdata", bus.rdata, 32'h1234_5678);
        tick();

        $display("[TB] read and write of reg2 in the same cycle");
        bus.araddr  = 40'h08;
        bus.arvalid = 1'b1;
        applyStimulus(40'h08, 32'hAABB_CCDD, 4'hF);
        bus.arvalid = 1'b0;
        expCtrl[2] = 32'hAABB_CCDD;
        checkOutput("rw_rdata", bus.rdata,    32'h1234_5678);
        checkOutput("rw_reg2",  ctrlO[95:64], expCtrl[2]);
        finishWrite();
        bus.rready = 1'b0;

        $display("[TB] write to status index, reads of unmapped indices");
        applyStimulus(40'h24, 32'hFFFF_FFFF, 4'hF);
        checkOutput("sw_ctrlwr", 32'(ctrlWrO),    32'h00);
        checkOutput("sw_bvalid", 32'(bus.bvalid), 32'd1);
        checkOutput("sw_bresp",  32'(bus.bresp),  32'(ERR_RESP));
        finishWrite();
        checkAllCtrl("sw");
        bus.araddr  = 40'(4 * (NUM_CTRL + NUM_STAT));
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        checkOutput("um_rvalid", 32'(bus.rvalid), 32'd1);
        checkOutput("um_rdata",  bus.rdata,       32'd0);
        checkOutput("um_rresp",  32'(bus.rresp),  32'(ERR_RESP));
        tick();
        bus.araddr  = 40'h04;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        checkOutput("ok_rdata", bus.rdata,      32'h0000_1111);
        checkOutput("ok_rresp", 32'(bus.rresp), 32'd0);
        tick();
        bus.rready = 1'b0;

        $display("[TB] reset while bvalid pending");
        applyStimulus(40'h04, 32'hCAFE_F00D, 4'hF);
        checkOutput("mr_bvalid1", 32'(bus.bvalid), 32'd1);
        checkOutput("mr_reg1a",   ctrlO[63:32],    32'hCAFE_F00D);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("mr_bvalid0", 32'(bus.bvalid),  32'd0);
        checkOutput("mr_reg1b",   ctrlO[63:32],     32'h0000_1111);
        checkOutput("mr_reg2",    ctrlO[95:64],     32'h0);
        checkOutput("mr_awready", 32'(bus.awready), 32'd1);
        tick();
        resetN = 1'b1;
        tick();
        checkOutput("mr_bvalid2", 32'(bus.bvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
